// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : reg_dump_reader
//  Description : Debug read-out engine for the CPU register file. On a start
//                request it walks a spare read port over an index range
//                (wrap-around allowed) and streams {index, value} pairs out
//                on a valid/ready interface. Never writes architectural state.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NREG  number of architectural registers (power of two)
//    AW    register index width, log2(NREG)
//    DW    register data width
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    start      in   dump request, sampled only in IDLE
//    first      in   first index to dump, latched with start
//    last       in   last index to dump, latched with start
//    abort      in   cancel a running dump (drops any pending beat)
//    rR         out  read address to the register file spare port
//    rD         in   combinational read data for rR
//    out_valid  out  output beat valid
//    out_ready  in   sink accepts the beat
//    out_idx    out  index of the current beat
//    out_data   out  register value of the current beat
//    busy       out  high while RUN or DRAIN
//    done       out  one-cycle pulse on normal completion
// ============================================================================
module reg_dump_reader #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  input  logic          abort,
  output logic [AW-1:0] rR,
  input  logic [DW-1:0] rD,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] C_IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] end_q, end_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          done_q, done_d;
  logic          w_free;

  // Output register can take a new beat when empty or being drained this edge.
  assign w_free = !out_valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      end_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      end_q       <= end_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    end_d       = end_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = first;
          end_d   = last;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (w_free) begin
          out_idx_d   = idx_q;
          out_data_d  = rD;
          out_valid_d = 1'b1;
          if (idx_q == end_q) begin
            state_d = S_DRAIN;
          end else begin
            // AW bits exactly cover NREG, so the add wraps modulo NREG.
            idx_d = idx_q + C_IDX_ONE;
          end
        end
      end

      S_DRAIN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign rR        = idx_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dump_reader
//  Description : Scoreboard testbench for reg_dump_reader. Stimulus pushes
//                expected beats into a queue; a monitor pops and compares on
//                every handshake, checks stall stability and counts done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_dump_reader;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] first;
  logic [AW-1:0] last;
  logic          abort;
  logic [AW-1:0] rR;
  logic [DW-1:0] rD;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [NREG];
  beat_t         exp_q [$];
  int            checks;
  int            errors;
  int            done_cnt;
  int            hs_cnt;

  logic          st_pend;
  logic [AW-1:0] st_idx;
  logic [DW-1:0] st_data;

  reg_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first     (first),
    .last      (last),
    .abort     (abort),
    .rR        (rR),
    .rD        (rD),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  assign rD = rf[rR];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      st_pend = 1'b0;
    end else begin
      if (st_pend) begin
        checks++;
        if (!out_valid || out_idx !== st_idx || out_data !== st_data) begin
          errors++;
          $display("FAIL stall_hold: actual v=%0b idx=%0d data=0x%0h required v=1 idx=%0d data=0x%0h",
                   out_valid, out_idx, out_data, st_idx, st_data);
        end
      end
      if (out_valid && out_ready && !abort) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: actual idx=%0d data=0x%0h required none", out_idx, out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (out_idx !== e.idx || out_data !== e.data) begin
            errors++;
            $display("FAIL beat: actual idx=%0d data=0x%0h required idx=%0d data=0x%0h",
                     out_idx, out_data, e.idx, e.data);
          end
        end
      end
      st_pend = out_valid && !out_ready && !abort;
      st_idx  = out_idx;
      st_data = out_data;
      if (done) done_cnt++;
    end
  end

  task automatic push_range(input int f, input int l);
    int i;
    beat_t b;
    i = f;
    forever begin
      b.idx  = AW'(i);
      b.data = rf[i];
      exp_q.push_back(b);
      if (i == l) break;
      i = (i + 1) % NREG;
    end
  endtask

  // Pulse start for one cycle; on return we are 1 time unit after edge E0.
  task automatic do_start(input int f, input int l);
    first = AW'(f);
    last  = AW'(l);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: actual no done required done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; hs_cnt = 0; st_pend = 1'b0;
    rst_n = 1'b0; start = 1'b0; first = '0; last = '0; abort = 1'b0; out_ready = 1'b0;
    for (int n = 0; n < NREG; n++) rf[n] = 32'h1000 + n;

    // ---------------- reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rR", 64'(rR), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- full dump with latency checks
    out_ready = 1'b1;
    push_range(0, 31);
    do_start(0, 31);
    chk("lat_rR", 64'(rR), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    chk("lat_valid_e0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_valid_e1", 64'(out_valid), 64'd1);
    chk("lat_idx_e1", 64'(out_idx), 64'd0);
    wait_done("full", 100);
    #1;
    chk("full_busy_at_done", 64'(busy), 64'd0);
    chk("full_left", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("full_done_once", 64'(done_cnt), 64'd1);
    chk("full_hs", 64'(hs_cnt), 64'd32);

    // ---------------- backpressure 4..7, ready 1,0,0,1,...
    push_range(4, 7);
    do_start(4, 7);
    begin
      int cyc;
      int d0;
      d0 = done_cnt;
      cyc = 0;
      while (done_cnt == d0 && cyc < 100) begin
        out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        @(posedge clk); #1;
        cyc++;
      end
      chk("bp_done", 64'(done_cnt), 64'(d0 + 1));
    end
    chk("bp_left", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b1;

    // ---------------- wrap-around 30..1
    push_range(30, 1);
    do_start(30, 1);
    wait_done("wrap", 50);
    chk("wrap_left", 64'(exp_q.size()), 64'd0);

    // ---------------- single beat at 5
    rf[5] = 32'hDEADBEEF;
    push_range(5, 5);
    @(posedge clk); #1;
    do_start(5, 5);
    wait_done("single", 50);
    chk("single_left", 64'(exp_q.size()), 64'd0);

    // ---------------- abort after 3rd of 8 beats
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_range(0, 2);
    do_start(0, 7);
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk("ab_left", 64'(exp_q.size()), 64'd0);
    chk("ab_pending", 64'(out_valid), 64'd1);
    begin
      int d0;
      d0 = done_cnt;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("ab_valid", 64'(out_valid), 64'd0);
      chk("ab_busy", 64'(busy), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("ab_no_done", 64'(done_cnt), 64'(d0));
    end
    out_ready = 1'b1;
    push_range(0, 0);
    do_start(0, 0);
    wait_done("post_abort", 50);
    chk("post_abort_left", 64'(exp_q.size()), 64'd0);

    // ---------------- start while busy, then reset mid-dump
    @(posedge clk); #1;
    push_range(0, 31);
    do_start(0, 31);
    repeat (3) @(posedge clk);
    #1;
    do_start(9, 9);
    repeat (4) @(posedge clk);
    #2;
    begin
      int d0;
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("mr_rR", 64'(rR), 64'd0);
      chk("mr_valid", 64'(out_valid), 64'd0);
      chk("mr_idx", 64'(out_idx), 64'd0);
      chk("mr_data", 64'(out_data), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("mr_idle_valid", 64'(out_valid), 64'd0);
      chk("mr_idle_busy", 64'(busy), 64'd0);
      chk("mr_no_done", 64'(done_cnt), 64'(d0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the CPU register file. On a start request it walks a spare read port of the register file over an index range (wrap-around allowed) and streams each `{index, value}` pair out on a valid/ready interface, e.g. towards a UART or debug FIFO. It sits beside the datapath and never writes architectural state.

## Interface
- `NREG`, 32: number of architectural registers; must be a power of two.
- `AW`, 5: register index width, log2(NREG).
- `DW`, 32: register data width.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  dump request; sampled only in IDLE.
- `first`  in  AW  first index to dump; latched with `start`.
- `last`  in  AW  last index to dump; latched with `start`.
- `abort`  in  1  cancel a running dump.
- `rR`  out  AW  read address to the register file spare port.
- `rD`  in  DW  combinational read data for `rR`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  sink accepts the beat.
- `out_idx`  out  AW  index of the current beat.
- `out_data`  out  DW  register value of the current beat.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 latches `idx`<=`first` and `end`<=`last`, then moves to RUN. `abort` is ignored in IDLE.
- RUN: `rR`=`idx`. The output register is free when `out_valid`=0 or `out_ready`=1. On a free edge the block:
  - loads `out_idx`<=`idx` and `out_data`<=`rD`;
  - sets `out_valid`<=1;
  - if `idx`==`end`, goes to DRAIN; otherwise `idx`<=`idx`+1 mod NREG.
- DRAIN: waits for `out_valid` && `out_ready`. On that edge it clears `out_valid`, pulses `done`, and returns to IDLE.
- Count is ((`last`-`first`) mod NREG)+1 beats, so 1..NREG.
  - `first`==`last` gives a single beat.
  - `first`>`last` wraps through NREG-1 to 0.
- `abort` in RUN or DRAIN: on the next edge, `out_valid`<=0 (any pending beat is dropped), state goes to IDLE, and `done` stays 0.
- `abort` takes priority over a handshake in the same cycle.
- `start` while `busy` is ignored.
- `first` and `last` are not re-sampled after acceptance.
- Values are live reads, not a coherent snapshot. A write-back committed before an index's read edge is visible in that beat.
- Register 0 is dumped like any other index.

## Timing
- Reset values: state IDLE, `idx`=0, `rR`=0, `out_valid`=0, `out_idx`=0, `out_data`=0, `busy`=0, `done`=0.
- `rR` is driven from the `idx` register and has no combinational path from inputs.
- Start latency: with `start` accepted at edge E0, `rR`=`first` during the following cycle, and `out_valid`=1 with the first beat after edge E1.
- Throughput: one beat per cycle while `out_ready`=1.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_idx`, `out_data` and `idx` hold.
- `done` is asserted in the cycle after the final handshake edge. `busy` falls at that same edge.
- A new `start` is accepted in the cycle `done` is high.
- Asynchronous reset mid-dump returns everything to reset values immediately. No `done` is produced.

## Test plan
- Full dump, `first`=0, `last`=31, `out_ready`=1, register file preloaded with Rn=0x1000+n → 32 consecutive beats with idx 0..31 and data 0x1000..0x101F. First beat visible 2 edges after `start`. `done` occurs once, after the 32nd handshake.
- Backpressure: `first`=4, `last`=7, `out_ready` toggling 1,0,0,1,… → beats 4,5,6,7 in order. Data stays stable while stalled. No beat is lost or duplicated.
- Wrap-around: `first`=30, `last`=1 → beats 30,31,0,1, then `done`.
- Single beat: `first`=`last`=5, R5=0xDEADBEEF → exactly one beat (5, 0xDEADBEEF), then `done`.
- Abort after the 3rd of 8 beats with `out_ready`=0 → `out_valid` low next cycle, `busy` low, no `done`. A following `start` 0..0 works normally.
- Reset mid-dump, plus `start` while busy → all outputs at reset values at once. The busy-time `start` produces no effect.
